// File: rtl/ifu_pkg.sv
// Shared widths, constants and the buffered-fetch record for the instruction fetch unit.
package ifu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] INST_NOP           = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        addr_t addr;
        inst_t inst;
    } fetch_t;

    function automatic addr_t word_align(input addr_t a);
        return a & ~addr_t'(3);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; used for both the instruction buffer and the issued-address queue.
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && empty && !flush));

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues word fetches on a req/gnt + rvalid bus,
// buffers returned words with their addresses and hands them to if_id under valid/ready.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_ena_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_gnt_i,
    input  logic              rom_rvalid_i,
    input  logic [INST_W-1:0] rom_rdata_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              id_ready_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    addr_t         pc;
    addr_t         last_addr;
    logic          rst_q;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW:0]   credit_used;

    logic          issue;
    logic          keep;
    logic          pop;

    addr_t         aq_head;
    logic [CW-1:0] aq_count;
    logic          aq_full;
    logic          aq_empty;

    fetch_t        buf_din;
    fetch_t        buf_head;
    logic [CW-1:0] buf_count;
    logic          buf_full;
    logic          buf_empty;

    // Outstanding fetches and buffered words share one credit pool so a response always has room.
    assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
    assign rom_req_o   = !rst_q && !jump_ena_i && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign rom_addr_o  = pc;

    assign issue = rom_req_o && rom_gnt_i;
    assign keep  = rom_rvalid_i && (discard == '0) && !jump_ena_i;
    assign pop   = !buf_empty && id_ready_i && !jump_ena_i;

    assign buf_din = '{addr: aq_head, inst: rom_rdata_i};

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (keep),
        .flush (jump_ena_i),
        .din   (pc),
        .dout  (aq_head),
        .count (aq_count),
        .full  (aq_full),
        .empty (aq_empty)
    );

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_t))
    ) u_inst_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .pop   (pop),
        .flush (jump_ena_i),
        .din   (buf_din),
        .dout  (buf_head),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_ADDR;
        end else if (jump_ena_i) begin
            pc <= word_align(jump_addr_i);
        end else if (issue) begin
            pc <= pc + addr_t'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({issue, rom_rvalid_i})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // A jump turns every fetch still in flight (beyond one returning now) into a stale response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            discard <= '0;
        end else if (jump_ena_i) begin
            discard <= outstanding - CW'(rom_rvalid_i);
        end else if (rom_rvalid_i && (discard != '0)) begin
            discard <= discard - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr <= RESET_ADDR;
        end else if (pop) begin
            last_addr <= buf_head.addr;
        end
    end

    assign inst_valid_o = !buf_empty;
    assign inst_o       = buf_empty ? INST_NOP  : buf_head.inst;
    assign inst_addr_o  = buf_empty ? last_addr : buf_head.addr;

    a_rvalid_needs_fetch: assert property (@(posedge clk) disable iff (rst)
        !(rom_rvalid_i && (outstanding == '0)));
    a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(keep && buf_full && !pop));
    a_addr_q_has_head: assert property (@(posedge clk) disable iff (rst)
        !(keep && aq_empty));
    a_addr_q_bounded: assert property (@(posedge clk) disable iff (rst)
        !(issue && aq_full) && (aq_count <= outstanding));

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: cycle tables act as the ROM and the consumer, outputs checked each cycle.
module tb_ifu;
    import ifu_pkg::*;

    logic        clk;
    logic        rst;
    logic        jump_ena_i;
    logic [31:0] jump_addr_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        id_ready_i;

    int checks;
    int failures;

    ifu #(
        .RESET_ADDR (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_ena_i   (jump_ena_i),
        .jump_addr_i  (jump_addr_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .id_ready_i   (id_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        jump;
        logic [31:0] jaddr;
        logic        gnt;
        logic        rv;
        logic [31:0] rv_addr;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    function automatic vec_t mk(input logic j, input logic [31:0] ja, input logic g,
                                input logic rv, input logic [31:0] ra, input logic rdy,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] eia);
        vec_t v;
        v.jump = j; v.jaddr = ja; v.gnt = g; v.rv = rv; v.rv_addr = ra; v.rdy = rdy;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_iaddr = eia;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] eia);
        chk({nm, ".req"},       32'(rom_req_o),    32'(er));
        chk({nm, ".rom_addr"},  rom_addr_o,        ea);
        chk({nm, ".valid"},     32'(inst_valid_o), 32'(ev));
        chk({nm, ".inst"},      inst_o,            ev ? inst_of(eia) : INST_NOP);
        chk({nm, ".inst_addr"}, inst_addr_o,       eia);
    endtask

    task automatic step(input string nm, input vec_t v);
        @(negedge clk);
        jump_ena_i   = v.jump;
        jump_addr_i  = v.jaddr;
        rom_gnt_i    = v.gnt;
        rom_rvalid_i = v.rv;
        rom_rdata_i  = v.rv ? inst_of(v.rv_addr) : 32'hDEAD_BEEF;
        id_ready_i   = v.rdy;
        #1;
        check_outs(nm, v.e_req, v.e_addr, v.e_valid, v.e_iaddr);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        jump_ena_i   = 1'b0;
        jump_addr_i  = '0;
        rom_gnt_i    = 1'b0;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = '0;
        id_ready_i   = 1'b0;

        //            jmp jaddr gnt rv rv_addr  rdy  req addr      valid iaddr
        tbl[0]  = mk(0, 0, 1, 0, 0,        1,   0, 32'h00, 0, 32'h00);
        tbl[1]  = mk(0, 0, 1, 0, 0,        1,   1, 32'h00, 0, 32'h00);
        tbl[2]  = mk(0, 0, 1, 1, 32'h00,   1,   1, 32'h04, 0, 32'h00);
        tbl[3]  = mk(0, 0, 1, 1, 32'h04,   1,   0, 32'h08, 1, 32'h00);
        tbl[4]  = mk(0, 0, 1, 0, 0,        1,   1, 32'h08, 1, 32'h04);
        tbl[5]  = mk(0, 0, 1, 1, 32'h08,   0,   1, 32'h0C, 0, 32'h04);
        tbl[6]  = mk(0, 0, 1, 1, 32'h0C,   0,   0, 32'h10, 1, 32'h08);
        tbl[7]  = mk(0, 0, 1, 0, 0,        0,   0, 32'h10, 1, 32'h08);
        tbl[8]  = mk(0, 0, 1, 0, 0,        1,   0, 32'h10, 1, 32'h08);
        tbl[9]  = mk(0, 0, 0, 0, 0,        1,   1, 32'h10, 1, 32'h0C);
        tbl[10] = mk(0, 0, 0, 0, 0,        1,   1, 32'h10, 0, 32'h0C);
        tbl[11] = mk(0, 0, 0, 0, 0,        1,   1, 32'h10, 0, 32'h0C);
        tbl[12] = mk(0, 0, 1, 0, 0,        1,   1, 32'h10, 0, 32'h0C);
        tbl[13] = mk(0, 0, 0, 1, 32'h10,   1,   1, 32'h14, 0, 32'h0C);
        tbl[14] = mk(0, 0, 0, 0, 0,        1,   1, 32'h14, 1, 32'h10);

        #2;
        check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Stream, back-pressure and grant stall.
        for (int i = 0; i < 15; i++) step($sformatf("tbl%0d", i), tbl[i]);

        // Jump to 0x103 with two fetches in flight; both stale words must vanish.
        step("jmp_a0", mk(0, 0,          1, 0, 0,       1, 1, 32'h14,  0, 32'h10));
        step("jmp_a1", mk(0, 0,          1, 0, 0,       1, 1, 32'h18,  0, 32'h10));
        step("jmp_a2", mk(1, 32'h103,    1, 0, 0,       1, 0, 32'h1C,  0, 32'h10));
        step("jmp_a3", mk(0, 0,          1, 1, 32'h14,  1, 0, 32'h100, 0, 32'h10));
        step("jmp_a4", mk(0, 0,          1, 1, 32'h18,  1, 1, 32'h100, 0, 32'h10));
        step("jmp_a5", mk(0, 0,          0, 0, 0,       1, 1, 32'h104, 0, 32'h10));
        step("jmp_a6", mk(0, 0,          0, 1, 32'h100, 1, 1, 32'h104, 0, 32'h10));
        step("jmp_a7", mk(0, 0,          0, 0, 0,       1, 1, 32'h104, 1, 32'h100));
        step("jmp_a8", mk(0, 0,          0, 0, 0,       1, 1, 32'h104, 0, 32'h100));

        // Jump coinciding with a response: that word drops, only one stale remains.
        step("jmp_b0", mk(0, 0,          1, 0, 0,       1, 1, 32'h104, 0, 32'h100));
        step("jmp_b1", mk(0, 0,          1, 0, 0,       1, 1, 32'h108, 0, 32'h100));
        step("jmp_b2", mk(1, 32'h200,    0, 1, 32'h104, 1, 0, 32'h10C, 0, 32'h100));
        step("jmp_b3", mk(0, 0,          1, 1, 32'h108, 1, 1, 32'h200, 0, 32'h100));
        step("jmp_b4", mk(0, 0,          0, 1, 32'h200, 1, 1, 32'h204, 0, 32'h100));
        step("jmp_b5", mk(0, 0,          0, 0, 0,       1, 1, 32'h204, 1, 32'h200));

        // PC wraps past the top of the address space.
        step("wrap0", mk(1, 32'hFFFF_FFFF, 1, 0, 0,            1, 0, 32'h204,       0, 32'h200));
        step("wrap1", mk(0, 0,             1, 0, 0,            1, 1, 32'hFFFF_FFFC, 0, 32'h200));
        step("wrap2", mk(0, 0,             0, 0, 0,            1, 1, 32'h0,         0, 32'h200));
        step("wrap3", mk(0, 0,             0, 1, 32'hFFFF_FFFC, 1, 1, 32'h0,         0, 32'h200));
        step("wrap4", mk(0, 0,             0, 0, 0,            1, 1, 32'h0,         1, 32'hFFFF_FFFC));

        // Reset while a word sits in the buffer, then restart from the reset address.
        step("rst_s0", mk(1, 32'h40, 0, 0, 0,       0, 0, 32'h0,  0, 32'hFFFF_FFFC));
        step("rst_s1", mk(0, 0,      1, 0, 0,       0, 1, 32'h40, 0, 32'hFFFF_FFFC));
        step("rst_s2", mk(0, 0,      0, 1, 32'h40,  0, 1, 32'h44, 0, 32'hFFFF_FFFC));
        step("rst_s3", mk(0, 0,      0, 0, 0,       0, 1, 32'h44, 1, 32'h40));
        #1 rst = 1'b1;
        #1;
        check_outs("rst_mid", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        step("rst_r0", mk(0, 0, 1, 0, 0, 1, 0, 32'h0, 0, 32'h0));
        step("rst_r1", mk(0, 0, 1, 0, 0, 1, 1, 32'h0, 0, 32'h0));
        step("rst_r2", mk(0, 0, 0, 0, 0, 1, 1, 32'h4, 0, 32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
